// File: rtl/secure_word_mux_if.sv
// Request/response bus for secure_word_mux: channel words and select in,
// one registered word out, valid/ready on both sides.
interface secure_word_mux_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned SEL_W  = 4
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]         sel;
  logic                     req_valid;
  logic                     req_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_err;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, sel, req_valid, out_ready,
    input  req_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  in_data, sel, req_valid, out_ready,
    output req_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/secure_word_mux.sv
// Registered, permission-checked N:1 word selector. Denied or out-of-range
// selects return zero with out_err and count as violations; too many locks it.
module secure_word_mux #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        NUM_CH     = 16,
  parameter int unsigned        SEL_W      = 4,
  parameter int unsigned        VIOL_LIMIT = 4,
  parameter logic [NUM_CH-1:0]  RST_MASK   = {NUM_CH{1'b1}}
) (
  input  logic                clk,
  input  logic                rst_n,
  secure_word_mux_if.slave    bus,
  input  logic [NUM_CH-1:0]   mask_in,
  input  logic                mask_we,
  output logic [7:0]          viol_cnt,
  output logic                locked,
  input  logic                unlock
);

  localparam int unsigned SelSpan = 1 << SEL_W;

  typedef enum logic {StOpen, StLocked} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [7:0]          viol_q, viol_d, viol_sat;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   sel_word;
  logic [SelSpan-1:0]  mask_ext;
  logic                accept, legal;

  // Zero-extending the mask to the full select range makes out-of-range
  // channels read as denied without a separate range compare.
  assign mask_ext = SelSpan'(mask_q);
  assign legal    = mask_ext[bus.sel];

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.sel == SEL_W'(i)) sel_word = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.req_ready = (state_q == StOpen) && (!valid_q || bus.out_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign viol_sat      = (viol_q == 8'hFF) ? viol_q : viol_q + 8'd1;

  always_comb begin
    state_d = state_q;
    viol_d  = viol_q;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    mask_d  = mask_we ? mask_in : mask_q;

    unique case (state_q)
      StLocked: begin
        if (unlock) begin
          state_d = StOpen;
          viol_d  = '0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      valid_d = 1'b1;
      if (legal) begin
        data_d = sel_word;
        err_d  = 1'b0;
      end else begin
        data_d = '0;
        err_d  = 1'b1;
        viol_d = viol_sat;
        if (viol_sat >= 8'(VIOL_LIMIT)) state_d = StLocked;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StOpen;
      mask_q  <= RST_MASK;
      viol_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      viol_q  <= viol_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = valid_q;
  assign viol_cnt      = viol_q;
  assign locked        = (state_q == StLocked);

endmodule
